// File: rtl/mux_stream_arb.sv
// mux_stream_arb: N-way stream multiplexer with a single registered output slot.
//
// Each cycle one input channel is granted from in_valid. The granted channel
// sees in_ready when the output slot is free (empty or being drained this
// cycle); a handshake loads its word into the output register one cycle later.
//
// Arbitration when force_en=0 is selected at build time by the macro
// MUX_STREAM_ARB_RR_EN:
//   defined   -> round-robin, search starts at the priority pointer
//   undefined -> fixed priority, lowest valid index wins
// With force_en=1 only channel force_sel may be granted (none if out of range).
//
// Ports:
//   clk        clock, rising edge
//   clrn       synchronous active-low reset
//   in_data    packed channel data, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, at most one bit set
//   force_en   manual-select enable
//   force_sel  channel forced when force_en=1
//   out_data   registered selected word
//   out_sel    index of the channel that supplied out_data
//   out_valid  out_data holds an untaken word
//   out_ready  downstream accepts out_data this cycle
module mux_stream_arb #(
    parameter int N_INPUTS   = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           clrn,
    input  logic [N_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [N_INPUTS-1:0]            in_valid,
    output logic [N_INPUTS-1:0]            in_ready,
    input  logic                           force_en,
    input  logic [$clog2(N_INPUTS)-1:0]    force_sel,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [$clog2(N_INPUTS)-1:0]    out_sel,
    output logic                           out_valid,
    input  logic                           out_ready
);

    localparam int SEL_W = $clog2(N_INPUTS);

    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0]      out_sel_q, out_sel_d;
    logic                  out_valid_q, out_valid_d;
    logic [SEL_W-1:0]      ptr_q, ptr_d;

    logic                  grant_vld;
    logic [SEL_W-1:0]      grant_idx;
    logic                  slot_free;
    logic                  xfer;

    assign slot_free = ~out_valid_q | out_ready;

    // Grant selection; only depends on in_valid through the arbitration itself.
    always_comb begin
        int               cand;
        logic [SEL_W-1:0] cidx;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cidx      = '0;
        if (force_en) begin
            if (int'(force_sel) < N_INPUTS) begin
                if (in_valid[force_sel]) begin
                    grant_vld = 1'b1;
                    grant_idx = force_sel;
                end
            end
        end else begin
`ifdef MUX_STREAM_ARB_RR_EN
            for (int k = 0; k < N_INPUTS; k++) begin
                cand = int'(ptr_q) + k;
                if (cand >= N_INPUTS) begin
                    cand = cand - N_INPUTS;
                end
                cidx = SEL_W'(cand);
                if (!grant_vld && in_valid[cidx]) begin
                    grant_vld = 1'b1;
                    grant_idx = cidx;
                end
            end
`else
            // Walk downwards so the lowest valid index is the last to win.
            for (int i = N_INPUTS - 1; i >= 0; i--) begin
                cidx = SEL_W'(i);
                if (in_valid[cidx]) begin
                    grant_vld = 1'b1;
                    grant_idx = cidx;
                end
            end
`endif
        end
    end

    // in_ready is forced low during reset so nothing handshakes into a word
    // that the reset is about to discard.
    always_comb begin
        in_ready = '0;
        if (clrn && slot_free && grant_vld) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    assign xfer = clrn & slot_free & grant_vld;

    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            // Load overrides drain so a simultaneous drain+load leaves no bubble.
            out_data_d  = in_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            out_sel_d   = grant_idx;
            out_valid_d = 1'b1;
            ptr_d       = (grant_idx == SEL_W'(N_INPUTS - 1)) ? '0 : grant_idx + 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_stream_arb.sv
// Self-checking bench for mux_stream_arb (N_INPUTS=4, DATA_WIDTH=32).
// A queue-based reference model is compared against the DUT on every falling
// edge; directed scenarios add literal expectations on top.
module tb_mux_stream_arb;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            clrn;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic            force_en;
    logic [1:0]      force_sel;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_sel;
    logic            out_valid;
    logic            out_ready;

    int checks = 0;
    int errors = 0;

    mux_stream_arb #(
        .N_INPUTS   (N),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .clrn      (clrn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .force_en  (force_en),
        .force_sel (force_sel),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [1:0]    sel;
        logic [DW-1:0] data;
    } word_t;

    word_t q[$];
    int    m_ptr  = 0;
    bit    m_init = 0;

    // Which channel the rules allow this cycle, -1 for none.
    function automatic int model_grant(logic [N-1:0] v, int ptr, logic fe, logic [1:0] fs);
        if (fe) begin
            if (int'(fs) < N && v[fs]) return int'(fs);
            return -1;
        end
`ifdef MUX_STREAM_ARB_RR_EN
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
`else
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
`endif
        return -1;
    endfunction

    always @(negedge clk) begin
        int           g;
        logic [N-1:0] exp_rdy;
        word_t        w;
        if (!clrn) begin
            chk("rst_in_ready", 64'(in_ready), 64'(0));
            q.delete();
            m_ptr  = 0;
            m_init = 1;
        end else if (m_init) begin
            chk("m_out_valid", 64'(out_valid), 64'(q.size() != 0));
            if (q.size() != 0) begin
                chk("m_out_data", 64'(out_data), 64'(q[0].data));
                chk("m_out_sel", 64'(out_sel), 64'(q[0].sel));
            end
            g       = model_grant(in_valid, m_ptr, force_en, force_sel);
            exp_rdy = '0;
            if (g >= 0 && (q.size() == 0 || out_ready)) exp_rdy[g] = 1'b1;
            chk("m_in_ready", 64'(in_ready), 64'(exp_rdy));
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (exp_rdy != 0) begin
                w.sel  = 2'(g);
                w.data = in_data[g*DW +: DW];
                q.push_back(w);
                m_ptr = (g + 1) % N;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [DW-1:0] ch [N];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pack();
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = ch[i];
    endtask

    initial begin
        int exp_rr [5];
        exp_rr = '{0, 1, 2, 3, 0};
        clrn      = 1'b0;
        in_valid  = 4'hF;
        force_en  = 1'b0;
        force_sel = 2'd0;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) ch[i] = 32'h1111_0000 + 32'(i);
        pack();
        #1;
        chk("rst_ready_zero", 64'(in_ready), 64'(0));
        tick();
        tick();
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_data", 64'(out_data), 64'(0));
        chk("rst_sel", 64'(out_sel), 64'(0));

        // Single-channel transfer with one-cycle latency.
        clrn     = 1'b1;
        in_valid = 4'b0100;
        ch[2]    = 32'hCAFE0002;
        pack();
        #1;
        chk("single_ready", 64'(in_ready), 64'(4'b0100));
        tick();
        in_valid = 4'b0000;
        chk("single_valid", 64'(out_valid), 64'(1));
        chk("single_data", 64'(out_data), 64'(32'hCAFE0002));
        chk("single_sel", 64'(out_sel), 64'(2));
        tick();

        // Reset so the pointer restarts at 0.
        clrn = 1'b0;
        tick();
        clrn = 1'b1;

`ifdef MUX_STREAM_ARB_RR_EN
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < N; i++) ch[i] = 32'h00C0_0000 | 32'(c << 4) | 32'(i);
            pack();
            in_valid = 4'b1111;
            #1;
            chk("rr_ready", 64'(in_ready), 64'(1 << exp_rr[c]));
            tick();
            chk("rr_valid", 64'(out_valid), 64'(1));
            chk("rr_sel", 64'(out_sel), 64'(exp_rr[c]));
            chk("rr_data", 64'(out_data), 64'(32'h00C0_0000 | 32'(c << 4) | 32'(exp_rr[c])));
        end
`else
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < N; i++) ch[i] = 32'h00F0_0000 | 32'(c << 4) | 32'(i);
            pack();
            in_valid = 4'b1010;
            #1;
            chk("fp_ready", 64'(in_ready), 64'(4'b0010));
            tick();
            chk("fp_sel", 64'(out_sel), 64'(1));
            chk("fp_data", 64'(out_data), 64'(32'h00F0_0000 | 32'(c << 4) | 32'd1));
        end
        chk("fp_exp_table", 64'(exp_rr[3]), 64'(3));
`endif
        in_valid = 4'b0000;
        tick();

        // Backpressure: hold A5 for three cycles, then drain and load together.
        ch[0]    = 32'h0000_00A5;
        pack();
        in_valid = 4'b0001;
        tick();
        out_ready = 1'b0;
        ch[1]     = 32'h0000_00B6;
        pack();
        in_valid  = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_ready", 64'(in_ready), 64'(0));
            chk("bp_data", 64'(out_data), 64'(32'h0000_00A5));
            chk("bp_valid", 64'(out_valid), 64'(1));
            tick();
        end
        chk("bp_hold_data", 64'(out_data), 64'(32'h0000_00A5));
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(in_ready), 64'(4'b0010));
        tick();
        in_valid = 4'b0000;
        chk("bp_next_valid", 64'(out_valid), 64'(1));
        chk("bp_next_data", 64'(out_data), 64'(32'h0000_00B6));
        chk("bp_next_sel", 64'(out_sel), 64'(1));
        tick();

        // Forced select, then reset while a word is pending.
        force_en  = 1'b1;
        force_sel = 2'd3;
        ch[0]     = 32'h0000_00D0;
        ch[3]     = 32'h0000_00D3;
        pack();
        in_valid  = 4'b1001;
        #1;
        chk("force_ready", 64'(in_ready), 64'(4'b1000));
        tick();
        chk("force_sel_out", 64'(out_sel), 64'(3));
        chk("force_data", 64'(out_data), 64'(32'h0000_00D3));
        force_en  = 1'b0;
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        clrn      = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(in_ready), 64'(0));
        tick();
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_data", 64'(out_data), 64'(0));
        chk("mid_rst_sel", 64'(out_sel), 64'(0));
        clrn      = 1'b1;
        out_ready = 1'b1;
        in_valid  = 4'b1001;
        #1;
        chk("post_rst_ready", 64'(in_ready), 64'(4'b0001));
        tick();
        chk("post_rst_sel", 64'(out_sel), 64'(0));
        chk("post_rst_data", 64'(out_data), 64'(32'h0000_00D0));

        // Mixed traffic, checked by the model alone.
        for (int c = 0; c < 80; c++) begin
            for (int i = 0; i < N; i++) ch[i] = $urandom;
            pack();
            in_valid  = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            force_en  = ($urandom_range(0, 5) == 0);
            force_sel = 2'($urandom_range(0, 3));
            tick();
        end
        in_valid  = 4'b0000;
        force_en  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_stream_arb.md
MUX_STREAM_ARB -- requirements
Module: mux_stream_arb

Interface
REQ-001 SHALL have parameter N_INPUTS, default 4, number of input channels (legal 2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, bit width of each data channel.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port clrn  input  1  reset; synchronous and active-low.
REQ-005 SHALL have port in_data  input  N_INPUTS*DATA_WIDTH  packed channel data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-006 SHALL have port in_valid  input  N_INPUTS  per-channel valid.
REQ-007 SHALL have port in_ready  output  N_INPUTS  per-channel ready; at most one bit high per cycle.
REQ-008 SHALL have port force_en  input  1  manual-select mode enable.
REQ-009 SHALL have port force_sel  input  $clog2(N_INPUTS)  channel forced when force_en=1.
REQ-010 SHALL have port out_data  output  DATA_WIDTH  registered selected data.
REQ-011 SHALL have port out_sel  output  $clog2(N_INPUTS)  index of the channel that supplied out_data.
REQ-012 SHALL have port out_valid  output  1  out_data holds an untaken word.
REQ-013 SHALL have port out_ready  input  1  downstream accepts out_data this cycle.

Function
REQ-014 SHALL define output slot free = ~out_valid | out_ready.
REQ-015 SHALL compute one combinational grant per cycle from in_valid: force_en=1 -> only channel force_sel is eligible; force_en=0 -> arbitration per Configuration.
REQ-016 SHALL assert in_ready[g] only for granted channel g, and only when the slot is free; in_ready SHALL NOT depend on in_valid of non-granted channels beyond arbitration.
REQ-017 SHALL on transfer (in_valid[g] & in_ready[g]) load out_data=channel g data, out_sel=g, out_valid=1 at the next edge; latency exactly 1 cycle.
REQ-018 SHALL on out_valid & out_ready with no new transfer clear out_valid at the next edge; simultaneous drain and load SHALL replace the word with no bubble (full throughput, 1 word/cycle).
REQ-019 SHALL hold out_data and out_sel stable while out_valid=1 & out_ready=0.
REQ-020 SHALL with force_en=1 and force_sel >= N_INPUTS grant no channel (all in_ready=0).
REQ-021 SHALL keep a priority pointer ptr (width $clog2(N_INPUTS)); on each transfer from channel g, ptr <= g+1, wrapping N_INPUTS-1 -> 0; ptr SHALL NOT change without a transfer; force-mode transfers also update ptr.
REQ-022 SHALL never drop or duplicate a word: each input handshake produces exactly one output handshake.

Reset
REQ-023 SHALL when clrn=0 at a rising edge set out_valid=0, out_data=0, out_sel=0, ptr=0.
REQ-024 SHALL hold in_ready all-zero while clrn=0.
REQ-025 SHALL on reset mid-operation discard any untaken output word; first post-reset grant follows ptr=0.

Configuration
REQ-026 SHALL use macro MUX_STREAM_ARB_RR_EN to select arbitration when force_en=0.
REQ-027 SHALL with MUX_STREAM_ARB_RR_EN defined grant the first valid channel searching ptr, ptr+1, ... wrapping modulo N_INPUTS (round-robin).
REQ-028 SHALL without MUX_STREAM_ARB_RR_EN grant the lowest-index valid channel (fixed priority); ptr SHALL still be maintained but SHALL NOT affect grant.

Verification (N_INPUTS=4, DATA_WIDTH=32, out_ready=1 unless stated)
REQ-029 SHALL cover: reset, then in_valid=4'b0100 data ch2=32'hCAFE0002 -> in_ready=4'b0100 that cycle; next cycle out_valid=1, out_data=32'hCAFE0002, out_sel=2.
REQ-030 SHALL cover (RR_EN defined): in_valid=4'b1111 held 5 cycles with distinct data -> out_sel sequence 0,1,2,3,0 (wrap), one word per cycle.
REQ-031 SHALL cover (RR_EN undefined): in_valid=4'b1010 held 3 cycles -> out_sel 1,1,1; channel 3 never granted.
REQ-032 SHALL cover: out_ready=0 for 3 cycles with out_valid=1, out_data=32'h0000_00A5 -> out_data stable, in_ready=0; on out_ready=1 same-cycle new transfer -> next word appears with out_valid staying 1.
REQ-033 SHALL cover: force_en=1, force_sel=3, in_valid=4'b1001 -> only ch3 granted; then clrn=0 one cycle with out_valid=1 -> out_valid=0, out_data=0, out_sel=0, next grant ch0 under RR.
